axi3_sram_responder: RTL and testbench
======================================

// Module: axi3_sram_responder
// PURPOSE
// AXI3 slave-side memory responder: the other end of the DMA engine's master port. Accepts
// INCR bursts on AW/W and AR, stores data in an internal word-wide SRAM array, and returns B/R
// responses. Serves one transaction at a time. It is the memory target in the DMAC subsystem
// and the bench, so DMA transfers (e.g. padded-matrix copies) run against real storage.
// PARAMETERS
// BASE_ADDR   32'h0000_0000  byte address of memory word 0 (4-byte aligned)
// DEPTH_LOG2  10             log2 of memory depth in 32-bit words (default 1024 words)
// PORTS
// clk        in   1   clock, all logic on rising edge
// rst_n      in   1   asynchronous active-low reset
// awid_i     in   4   write ID; latched and returned on bid_o
// awaddr_i   in   32  write burst start byte address
// awlen_i    in   4   beats-1 (1..16 beats)
// awsize_i   in   3   beat size; only 3'b010 supported
// awburst_i  in   2   burst type; only 2'b01 (INCR) supported
// awvalid_i  in   1   AW valid
// awready_o  out  1   AW ready
// wid_i      in   4   ignored
// wdata_i    in   32  write data
// wstrb_i    in   4   byte enables; bit k writes wdata_i[8k+7:8k]
// wlast_i    in   1   last write beat marker (checked, not used to end the burst)
// wvalid_i   in   1   W valid
// wready_o   out  1   W ready
// bid_o      out  4   latched awid
// bresp_o    out  2   2'b00 OKAY / 2'b10 SLVERR
// bvalid_o   out  1   B valid
// bready_i   in   1   B ready
// arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i: in, 4/32/4/3/2/1, as AW
// arready_o  out  1   AR ready
// rid_o      out  4   latched arid
// rdata_o    out  32  read data
// rresp_o    out  2   per-beat OKAY/SLVERR
// rlast_o    out  1   high on final beat
// rvalid_o   out  1   R valid
// rready_i   in   1   R ready
// BEHAVIOUR
// - FSM: S_IDLE, S_WDATA, S_WRESP, S_RDATA. Async reset -> S_IDLE; all *valid_o/*ready_o,
//   rlast_o = 0; bid/rid/bresp/rresp/rdata = 0. SRAM contents are NOT reset. Reset mid-burst
//   abandons the burst silently; beats already written stay written.
// - S_IDLE: awready_o = awvalid_i & (~arvalid_i | prio_w); arready_o = arvalid_i & (~awvalid_i
//   | ~prio_w). Readies are 0 outside S_IDLE and while rst_n = 0. prio_w resets to 1 and flips
//   on every grant, so simultaneous AW+AR alternate write, read, write, ...
// - AW handshake (cycle N): latch id, addr, len, error flag; beat counter <= 0; S_WDATA;
//   wready_o = 1 from N+1 until the final beat is accepted.
// - S_WDATA: each W handshake writes strobed bytes to word (addr-BASE_ADDR)>>2, then addr += 4.
//   Burst ends when the counter equals the latched len, regardless of wlast_i. Final beat at
//   cycle M -> S_WRESP, bvalid_o = 1 at M+1, held with bid/bresp stable until bready_i; then
//   S_IDLE at the next cycle.
// - bresp = SLVERR if awsize != 3'b010, awburst != 2'b01, any beat address is out of range,
//   or wlast_i mismatches (high before the last beat or low on it); otherwise OKAY. Erroring
//   beats (range/size/burst) are not written; all len+1 beats are always consumed.
// - AR handshake (cycle N): latch id, addr, len; rdata/rresp register loaded with beat 0;
//   rvalid_o = 1 at N+1. On each R handshake the register loads the next beat at the same
//   edge, so rvalid_o stays high (1 beat/clk at rready_i = 1). rlast_o high on beat len.
//   Handshake on the last beat -> rvalid_o = 0, S_IDLE next cycle.
// - Read beat error (out of range or unsupported size/burst): rdata = 0, rresp = SLVERR for
//   that beat. Always len+1 beats.
// - In range: BASE_ADDR <= addr < BASE_ADDR + 4*2^DEPTH_LOG2; addr[1:0] ignored. Address
//   arithmetic is 32-bit. A burst crossing the top of memory errors only on the beats past the
//   end; no wrap-around to word 0.
// - Payload outputs are stable while valid is high and ready is low (AXI stability rule).
// TESTING
// - AW(id 3, addr BASE+0x10, len 3) + 4 beats 0xA0..0xA3, wlast on beat 3 -> bvalid 1 clk after
//   last beat, bid=3, bresp=00; then AR (id 5) same addr len 3 -> rid=5, data 0xA0..0xA3, rlast on 4th.
// - Read with rready toggling 1,0,0,1,... -> rdata/rlast held stable while stalled; no beat lost.
// - awvalid and arvalid asserted in the same cycle twice -> grant order W, R, W, R.
// - Write burst starting at last word (BASE+4*1023, len 1) -> beat 0 written, beat 1 dropped,
//   bresp=10; read back same burst -> rresp 00 then 10 with rdata 0.
// - wstrb=4'b0101, data 0xFFFF_FFFF over word 0x1234_5678 -> readback 0x12FF_56FF.
// - Assert rst_n low mid read burst (beat 2 of 4) -> rvalid_o = 0 immediately, arready_o
//   follows arvalid_i after release, and earlier written memory data is intact.

Source files
------------

// File: rtl/axi3_sram_responder.sv
// AXI3 slave memory target: INCR bursts on AW/W and AR against an internal word-wide SRAM,
// one transaction at a time, with B/R responses and per-beat SLVERR on range/size/burst errors.
module axi3_sram_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [3:0]  awlen_i,
  input  logic [2:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [3:0]  wid_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [3:0]  arlen_i,
  input  logic [2:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_WRESP = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_prio_w;
  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [3:0]  r_cnt;
  logic        r_cfg_err;
  logic        r_werr;
  logic [3:0]  r_bid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_rid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rlast;
  logic        r_rvalid;
  logic [31:0] r_mem [DEPTH];

  logic        w_idle;
  logic        w_aw_hs;
  logic        w_ar_hs;
  logic        w_w_hs;
  logic        w_r_hs;
  logic        w_wlast_exp;
  logic        w_wbeat_err;
  logic        w_we;
  logic [31:0] w_rd_addr;
  logic        w_rd_err;
  logic [31:0] w_rd_word;
  logic        w_unused;

  function automatic logic f_in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && (((addr - BASE_ADDR) >> (DEPTH_LOG2 + 2)) == 32'd0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] f_word_idx(input logic [31:0] addr);
    return DEPTH_LOG2'((addr - BASE_ADDR) >> 2);
  endfunction

  function automatic logic f_cfg_err(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'b010) || (burst != 2'b01);
  endfunction

  assign w_unused    = ^wid_i;
  assign w_idle      = (r_state == S_IDLE);
  assign awready_o   = rst_n & w_idle & awvalid_i & (~arvalid_i | r_prio_w);
  assign arready_o   = rst_n & w_idle & arvalid_i & (~awvalid_i | ~r_prio_w);
  assign wready_o    = (r_state == S_WDATA);
  assign bvalid_o    = (r_state == S_WRESP);
  assign w_aw_hs     = awvalid_i & awready_o;
  assign w_ar_hs     = arvalid_i & arready_o;
  assign w_w_hs      = wvalid_i & wready_o;
  assign w_r_hs      = r_rvalid & rready_i;
  assign w_wlast_exp = (r_cnt == r_len);
  assign w_wbeat_err = r_cfg_err | ~f_in_range(r_addr);
  assign w_we        = w_w_hs & ~w_wbeat_err;

  // The read beat source is the AR channel at the handshake, the running address afterwards.
  assign w_rd_addr = w_ar_hs ? araddr_i : r_addr;
  assign w_rd_err  = (w_ar_hs ? f_cfg_err(arsize_i, arburst_i) : r_cfg_err) | ~f_in_range(w_rd_addr);
  assign w_rd_word = r_mem[f_word_idx(w_rd_addr)];

  assign bid_o    = r_bid;
  assign bresp_o  = r_bresp;
  assign rid_o    = r_rid;
  assign rdata_o  = r_rdata;
  assign rresp_o  = r_rresp;
  assign rlast_o  = r_rlast;
  assign rvalid_o = r_rvalid;

  // SRAM byte-lane write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_i[k]) begin
          r_mem[f_word_idx(r_addr)][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered response channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_prio_w  <= 1'b1;
      r_addr    <= 32'd0;
      r_len     <= 4'd0;
      r_cnt     <= 4'd0;
      r_cfg_err <= 1'b0;
      r_werr    <= 1'b0;
      r_bid     <= 4'd0;
      r_bresp   <= 2'b00;
      r_rid     <= 4'd0;
      r_rdata   <= 32'd0;
      r_rresp   <= 2'b00;
      r_rlast   <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_aw_hs) begin
            r_bid     <= awid_i;
            r_addr    <= awaddr_i;
            r_len     <= awlen_i;
            r_cnt     <= 4'd0;
            r_cfg_err <= f_cfg_err(awsize_i, awburst_i);
            r_werr    <= 1'b0;
            r_prio_w  <= ~r_prio_w;
            r_state   <= S_WDATA;
          end else if (w_ar_hs) begin
            r_rid     <= arid_i;
            r_addr    <= araddr_i + 32'd4;
            r_len     <= arlen_i;
            r_cnt     <= 4'd0;
            r_cfg_err <= f_cfg_err(arsize_i, arburst_i);
            r_rdata   <= w_rd_err ? 32'd0 : w_rd_word;
            r_rresp   <= w_rd_err ? 2'b10 : 2'b00;
            r_rlast   <= (arlen_i == 4'd0);
            r_rvalid  <= 1'b1;
            r_prio_w  <= ~r_prio_w;
            r_state   <= S_RDATA;
          end
        end
        S_WDATA: begin
          if (w_w_hs) begin
            r_werr <= r_werr | w_wbeat_err | (wlast_i != w_wlast_exp);
            r_addr <= r_addr + 32'd4;
            r_cnt  <= r_cnt + 4'd1;
            if (w_wlast_exp) begin
              r_bresp <= (r_werr | w_wbeat_err | ~wlast_i) ? 2'b10 : 2'b00;
              r_state <= S_WRESP;
            end
          end
        end
        S_WRESP: begin
          if (bready_i) begin
            r_state <= S_IDLE;
          end
        end
        S_RDATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_rdata <= w_rd_err ? 32'd0 : w_rd_word;
              r_rresp <= w_rd_err ? 2'b10 : 2'b00;
              r_addr  <= r_addr + 32'd4;
              r_cnt   <= r_cnt + 4'd1;
              r_rlast <= ((r_cnt + 4'd1) == r_len);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi3_sram_responder.sv
// Directed bench for axi3_sram_responder: single-beat vector table plus burst,
// stall, arbitration, boundary, error and mid-burst reset sequences.
module tb_axi3_sram_responder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  awid_i;
  logic [31:0] awaddr_i;
  logic [3:0]  awlen_i;
  logic [2:0]  awsize_i;
  logic [1:0]  awburst_i;
  logic        awvalid_i;
  logic        awready_o;
  logic [3:0]  wid_i;
  logic [31:0] wdata_i;
  logic [3:0]  wstrb_i;
  logic        wlast_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [3:0]  bid_o;
  logic [1:0]  bresp_o;
  logic        bvalid_o;
  logic        bready_i;
  logic [3:0]  arid_i;
  logic [31:0] araddr_i;
  logic [3:0]  arlen_i;
  logic [2:0]  arsize_i;
  logic [1:0]  arburst_i;
  logic        arvalid_i;
  logic        arready_o;
  logic [3:0]  rid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        rlast_o;
  logic        rvalid_o;
  logic        rready_i;

  int n_checks;
  int n_errors;
  logic [31:0] exp_rd [16];
  logic [1:0]  exp_rr [16];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;
  vec_t vecs [9];

  axi3_sram_responder #(.BASE_ADDR(32'h0000_0000), .DEPTH_LOG2(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
    .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    awid_i = id; awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst;
    awvalid_i = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (awready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    awvalid_i = 1'b0;
    if (!ok) chk("aw_timeout", 32'd0, 32'd1);
  endtask

  task automatic ar_phase(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    arid_i = id; araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst;
    arvalid_i = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (arready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    arvalid_i = 1'b0;
    if (!ok) chk("ar_timeout", 32'd0, 32'd1);
  endtask

  // Beats carry base+i; bad_beat inverts wlast on that beat (-1 for none).
  task automatic w_phase(input logic [3:0] len, input logic [31:0] base, input logic [3:0] strb,
                         input int bad_beat, input logic [3:0] exp_bid, input logic [1:0] exp_bresp);
    bit ok;
    for (int i = 0; i <= int'(len); i++) begin
      wdata_i = base + 32'(i);
      wstrb_i = strb;
      wlast_i = (i == int'(len));
      if (i == bad_beat) wlast_i = ~wlast_i;
      wvalid_i = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (wready_o) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
      if (!ok) chk("w_timeout", 32'd0, 32'd1);
    end
    wvalid_i = 1'b0;
    wlast_i = 1'b0;
    chk("bvalid_timing", 32'(bvalid_o), 32'd1);
    chk("wready_drop", 32'(wready_o), 32'd0);
    @(negedge clk);
    chk("bvalid_hold", 32'(bvalid_o), 32'd1);
    chk("bid", 32'(bid_o), 32'(exp_bid));
    chk("bresp", 32'(bresp_o), 32'(exp_bresp));
    @(posedge clk); #1;
    bready_i = 1'b1;
    @(posedge clk); #1;
    bready_i = 1'b0;
    chk("bvalid_clear", 32'(bvalid_o), 32'd0);
  endtask

  // mode 0: rready always high; mode 1: rready pattern 1,0,0 repeating.
  task automatic r_phase(input logic [3:0] len, input logic [3:0] exp_rid, input int mode);
    int beat;
    bit have_prev;
    logic [31:0] prev_data;
    logic [1:0]  prev_resp;
    logic        prev_last;
    beat = 0;
    have_prev = 1'b0;
    prev_data = 32'd0; prev_resp = 2'b00; prev_last = 1'b0;
    for (int c = 0; c < 100 && beat <= int'(len); c++) begin
      rready_i = (mode == 0) ? 1'b1 : (c % 3 == 0);
      @(negedge clk);
      chk("rvalid_cont", 32'(rvalid_o), 32'd1);
      if (!rvalid_o) break;
      if (have_prev) begin
        chk("rdata_stable", rdata_o, prev_data);
        chk("rlast_stable", 32'(rlast_o), 32'(prev_last));
        chk("rresp_stable", 32'(rresp_o), 32'(prev_resp));
      end
      if (rready_i) begin
        chk("rdata", rdata_o, exp_rd[beat]);
        chk("rresp", 32'(rresp_o), 32'(exp_rr[beat]));
        chk("rid", 32'(rid_o), 32'(exp_rid));
        chk("rlast", 32'(rlast_o), 32'(beat == int'(len)));
        beat++;
        have_prev = 1'b0;
      end else begin
        have_prev = 1'b1;
        prev_data = rdata_o; prev_resp = rresp_o; prev_last = rlast_o;
      end
      @(posedge clk); #1;
    end
    rready_i = 1'b0;
    if (beat <= int'(len)) chk("r_timeout", 32'(beat), 32'(len) + 32'd1);
    chk("rvalid_end", 32'(rvalid_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic arb(input bit expect_w, input logic [31:0] val);
    awid_i = 4'd1; awaddr_i = 32'h40; awlen_i = 4'd0; awsize_i = 3'b010; awburst_i = 2'b01;
    arid_i = 4'd2; araddr_i = 32'h40; arlen_i = 4'd0; arsize_i = 3'b010; arburst_i = 2'b01;
    awvalid_i = 1'b1;
    arvalid_i = 1'b1;
    @(negedge clk);
    chk("arb_awready", 32'(awready_o), 32'(expect_w));
    chk("arb_arready", 32'(arready_o), 32'(!expect_w));
    @(posedge clk); #1;
    awvalid_i = 1'b0;
    arvalid_i = 1'b0;
    if (expect_w) begin
      w_phase(4'd0, val, 4'hF, -1, 4'd1, 2'b00);
    end else begin
      exp_rd[0] = val; exp_rr[0] = 2'b00;
      r_phase(4'd0, 4'd2, 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{32'h0000_0000, 32'h1234_5678, 4'hF, 2'b00, 32'h1234_5678, 2'b00};
    vecs[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 4'b0101, 2'b00, 32'h12FF_56FF, 2'b00};
    vecs[2] = '{32'h0000_0004, 32'hCAFE_BABE, 4'hF, 2'b00, 32'hCAFE_BABE, 2'b00};
    vecs[3] = '{32'h0000_0006, 32'h1122_3344, 4'b1100, 2'b00, 32'h1122_BABE, 2'b00};
    vecs[4] = '{32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
    vecs[5] = '{32'h0000_0FFC, 32'h0BAD_F00D, 4'hF, 2'b00, 32'h0BAD_F00D, 2'b00};
    vecs[6] = '{32'h0000_0008, 32'h55AA_55AA, 4'hF, 2'b00, 32'h55AA_55AA, 2'b00};
    vecs[7] = '{32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h55AA_55AA, 2'b00};
    vecs[8] = '{32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 2'b10, 32'h0000_0000, 2'b10};

    rst_n = 1'b0;
    awid_i = 4'd0; awaddr_i = 32'd0; awlen_i = 4'd0; awsize_i = 3'b010; awburst_i = 2'b01;
    awvalid_i = 1'b1;
    wid_i = 4'd0; wdata_i = 32'd0; wstrb_i = 4'h0; wlast_i = 1'b0; wvalid_i = 1'b0;
    bready_i = 1'b0;
    arid_i = 4'd0; araddr_i = 32'd0; arlen_i = 4'd0; arsize_i = 3'b010; arburst_i = 2'b01;
    arvalid_i = 1'b1;
    rready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(awready_o), 32'd0);
    chk("rst_arready", 32'(arready_o), 32'd0);
    chk("rst_wready", 32'(wready_o), 32'd0);
    chk("rst_bvalid", 32'(bvalid_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rlast", 32'(rlast_o), 32'd0);
    chk("rst_bid_bresp", {26'd0, bid_o, bresp_o}, 32'd0);
    chk("rst_rid_rresp", {26'd0, rid_o, rresp_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    awvalid_i = 1'b0;
    arvalid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat write then readback, one record per entry.
    for (int i = 0; i < 9; i++) begin
      aw_phase(4'(i), vecs[i].addr, 4'd0, 3'b010, 2'b01);
      w_phase(4'd0, vecs[i].wdata, vecs[i].strb, -1, 4'(i), vecs[i].bresp);
      exp_rd[0] = vecs[i].rdata;
      exp_rr[0] = vecs[i].rresp;
      ar_phase(4'(i + 5), vecs[i].addr, 4'd0, 3'b010, 2'b01);
      r_phase(4'd0, 4'(i + 5), 0);
    end

    // Four-beat burst, back-to-back read, then stalled read.
    aw_phase(4'd3, 32'h10, 4'd3, 3'b010, 2'b01);
    w_phase(4'd3, 32'hA0, 4'hF, -1, 4'd3, 2'b00);
    for (int i = 0; i < 4; i++) begin
      exp_rd[i] = 32'hA0 + 32'(i);
      exp_rr[i] = 2'b00;
    end
    ar_phase(4'd5, 32'h10, 4'd3, 3'b010, 2'b01);
    r_phase(4'd3, 4'd5, 0);
    ar_phase(4'd6, 32'h10, 4'd3, 3'b010, 2'b01);
    r_phase(4'd3, 4'd6, 1);

    // wlast early on beat 0, then wlast missing on the last beat: data still lands.
    aw_phase(4'd7, 32'h50, 4'd1, 3'b010, 2'b01);
    w_phase(4'd1, 32'h500, 4'hF, 0, 4'd7, 2'b10);
    aw_phase(4'd8, 32'h58, 4'd1, 3'b010, 2'b01);
    w_phase(4'd1, 32'h580, 4'hF, 1, 4'd8, 2'b10);
    exp_rd[0] = 32'h500; exp_rd[1] = 32'h501; exp_rd[2] = 32'h580; exp_rd[3] = 32'h581;
    for (int i = 0; i < 4; i++) exp_rr[i] = 2'b00;
    ar_phase(4'd9, 32'h50, 4'd3, 3'b010, 2'b01);
    r_phase(4'd3, 4'd9, 0);

    // Unsupported size/burst: SLVERR and no write; unsupported read size returns zero.
    aw_phase(4'd2, 32'h30, 4'd0, 3'b010, 2'b01);
    w_phase(4'd0, 32'h3030, 4'hF, -1, 4'd2, 2'b00);
    aw_phase(4'd2, 32'h30, 4'd0, 3'b001, 2'b01);
    w_phase(4'd0, 32'hBAD0, 4'hF, -1, 4'd2, 2'b10);
    aw_phase(4'd2, 32'h30, 4'd0, 3'b010, 2'b10);
    w_phase(4'd0, 32'hBAD1, 4'hF, -1, 4'd2, 2'b10);
    exp_rd[0] = 32'h3030; exp_rr[0] = 2'b00;
    ar_phase(4'd4, 32'h30, 4'd0, 3'b010, 2'b01);
    r_phase(4'd0, 4'd4, 0);
    exp_rd[0] = 32'd0; exp_rr[0] = 2'b10;
    ar_phase(4'd4, 32'h30, 4'd0, 3'b001, 2'b01);
    r_phase(4'd0, 4'd4, 0);

    // Burst over the top word: second beat dropped, no wrap into word 0.
    aw_phase(4'd1, 32'hFFC, 4'd1, 3'b010, 2'b01);
    w_phase(4'd1, 32'h77, 4'hF, -1, 4'd1, 2'b10);
    exp_rd[0] = 32'h77; exp_rr[0] = 2'b00;
    exp_rd[1] = 32'h0;  exp_rr[1] = 2'b10;
    ar_phase(4'd1, 32'hFFC, 4'd1, 3'b010, 2'b01);
    r_phase(4'd1, 4'd1, 0);
    exp_rd[0] = 32'h12FF_56FF; exp_rr[0] = 2'b00;
    ar_phase(4'd1, 32'h0, 4'd0, 3'b010, 2'b01);
    r_phase(4'd0, 4'd1, 0);

    // Simultaneous AW/AR alternate starting with write after reset.
    do_reset();
    @(posedge clk); #1;
    arb(1'b1, 32'h100);
    arb(1'b0, 32'h100);
    arb(1'b1, 32'h200);
    arb(1'b0, 32'h200);

    // Reset in the middle of a read burst.
    ar_phase(4'd5, 32'h10, 4'd3, 3'b010, 2'b01);
    rready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_rdata", rdata_o, 32'hA2);
    rst_n = 1'b0;
    rready_i = 1'b0;
    arid_i = 4'd5; araddr_i = 32'h10; arlen_i = 4'd3; arsize_i = 3'b010; arburst_i = 2'b01;
    arvalid_i = 1'b1;
    #1;
    chk("midrst_rvalid", 32'(rvalid_o), 32'd0);
    chk("midrst_arready", 32'(arready_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", 32'(arready_o), 32'd1);
    @(posedge clk); #1;
    arvalid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_rd[i] = 32'hA0 + 32'(i);
      exp_rr[i] = 2'b00;
    end
    r_phase(4'd3, 4'd5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
